// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg
//   Constants shared by the convolution window scheduler: image geometry,
//   data width, tap count, result-memory select codes and FSM state codes.
//   No ports.
package conv_sched_pkg;

    localparam int IMG_W  = 64;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int ROW_W  = ADDR_W / 2;
    localparam int N_TAPS = 9;

    // Fetch counter value of the capture-only cycle (no address issued).
    localparam logic [3:0] K_CAPT = 4'(N_TAPS);

    localparam logic [ROW_W-1:0] RC_MAX = ROW_W'(IMG_W - 1);

    localparam logic [1:0] CSEL_NONE = 2'd0;
    localparam logic [1:0] CSEL_F0   = 2'd1;
    localparam logic [1:0] CSEL_F1   = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/conv_sched_if.sv
// conv_sched_if
//   Bundles the scheduler's handshake, image-read, datapath and result-write
//   signals.
//   slave  : seen by conv_sched (start/idata/k_ovalid/k_res* in, rest out)
//   master : seen by the environment driving the scheduler
interface conv_sched_if;
    import conv_sched_pkg::*;

    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        iaddr;
    logic [DATA_W-1:0]        idata;
    logic                     k_valid;
    logic [N_TAPS*DATA_W-1:0] k_data;
    logic                     k_ovalid;
    logic [DATA_W-1:0]        k_res0;
    logic [DATA_W-1:0]        k_res1;
    logic                     cwr;
    logic [ADDR_W-1:0]        caddr;
    logic [DATA_W-1:0]        cdata;
    logic [1:0]               csel;

    modport slave (
        input  start, idata, k_ovalid, k_res0, k_res1,
        output busy, done, iaddr, k_valid, k_data, cwr, caddr, cdata, csel
    );

    modport master (
        output start, idata, k_ovalid, k_res0, k_res1,
        input  busy, done, iaddr, k_valid, k_data, cwr, caddr, cdata, csel
    );

endinterface

// File: rtl/conv_win_addr.sv
// conv_win_addr
//   Maps a window centre (row, col) and tap index k = (dy+1)*3 + (dx+1)
//   to the row-major pixel address and an in-bounds flag.
//   row_i, col_i : window centre
//   k_i          : tap index 0..8 (anything else reports out of bounds)
//   addr_o       : row*IMG_W + col of the tap, 0 when out of bounds
//   inb_o        : tap lies inside the image
module conv_win_addr
    import conv_sched_pkg::*;
(
    input  logic [ROW_W-1:0]  row_i,
    input  logic [ROW_W-1:0]  col_i,
    input  logic [3:0]        k_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              inb_o
);

    localparam logic [ROW_W:0] EDGE = (ROW_W+1)'(IMG_W);

    logic [1:0]       dy;
    logic [1:0]       dx;
    logic             k_ok;
    logic [ROW_W:0]   r_p;
    logic [ROW_W:0]   c_p;
    logic [ROW_W-1:0] r_t;
    logic [ROW_W-1:0] c_t;

    // Offsets are held as 0..2 (meaning -1..+1) so all sums stay unsigned;
    // r_p/c_p are therefore the tap coordinate plus one.
    always_comb begin
        dy   = 2'd1;
        dx   = 2'd1;
        k_ok = 1'b1;
        case (k_i)
            4'd0:    begin dy = 2'd0; dx = 2'd0; end
            4'd1:    begin dy = 2'd0; dx = 2'd1; end
            4'd2:    begin dy = 2'd0; dx = 2'd2; end
            4'd3:    begin dy = 2'd1; dx = 2'd0; end
            4'd4:    begin dy = 2'd1; dx = 2'd1; end
            4'd5:    begin dy = 2'd1; dx = 2'd2; end
            4'd6:    begin dy = 2'd2; dx = 2'd0; end
            4'd7:    begin dy = 2'd2; dx = 2'd1; end
            4'd8:    begin dy = 2'd2; dx = 2'd2; end
            default: k_ok = 1'b0;
        endcase
    end

    assign r_p = {1'b0, row_i} + {{(ROW_W-1){1'b0}}, dy};
    assign c_p = {1'b0, col_i} + {{(ROW_W-1){1'b0}}, dx};

    // Modular subtract is exact whenever the tap is in bounds (r_p in 1..IMG_W).
    assign r_t = r_p[ROW_W-1:0] - ROW_W'(1);
    assign c_t = c_p[ROW_W-1:0] - ROW_W'(1);

    assign inb_o = k_ok && (r_p != '0) && (r_p <= EDGE)
                        && (c_p != '0) && (c_p <= EDGE);

    // IMG_W is a power of two, so row*IMG_W + col is a concatenation.
    assign addr_o = inb_o ? {r_t, c_t} : '0;

endmodule

// File: rtl/conv_sched.sv
// conv_sched
//   Walks every pixel of a square image in raster order, fetches its 3x3
//   neighbourhood (zero padded) from a synchronous-read image memory,
//   hands the window to a two-filter datapath and writes the two results
//   back to the filter-0 / filter-1 result memories at the centre address.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : conv_sched_if.slave (start/busy/done, image read port,
//                datapath window/result strobes, result write port)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_FETCH  | 9 tap addresses + 1 capture cycle for the current window
//   ST_ISSUE  | k_valid for one cycle, latch centre address, advance
//   ST_FINISH | last window issued, waiting for its second result write
module conv_sched
    import conv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    conv_sched_if.slave bus
);

    logic [1:0]                    state_q, state_d;
    logic [3:0]                    fcnt_q, fcnt_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic [ROW_W-1:0]              col_q, col_d;
    logic                          inb_prev_q, inb_prev_d;
    logic [N_TAPS-1:0][DATA_W-1:0] taps_q, taps_d;
    logic [ADDR_W-1:0]             pend_addr_q, pend_addr_d;
    logic                          outst_q, outst_d;
    logic                          second_q, second_d;
    logic [DATA_W-1:0]             res1_q, res1_d;
    logic                          cwr_q, cwr_d;
    logic [1:0]                    csel_q, csel_d;
    logic [ADDR_W-1:0]             caddr_q, caddr_d;
    logic [DATA_W-1:0]             cdata_q, cdata_d;

    logic [ADDR_W-1:0] tap_addr;
    logic              tap_inb;
    logic              last_win;
    logic              ov_acc;
    logic              done_w;

    conv_win_addr u_win_addr (
        .row_i  (row_q),
        .col_i  (col_q),
        .k_i    (fcnt_q),
        .addr_o (tap_addr),
        .inb_o  (tap_inb)
    );

    assign last_win = (row_q == RC_MAX) && (col_q == RC_MAX);

    // outst_q marks a window whose results are still owed to us; results
    // from work launched before a reset find it clear and are dropped.
    assign ov_acc = bus.k_ovalid && outst_q;

    assign done_w = (state_q == ST_FINISH) && cwr_q && (csel_q == CSEL_F1);

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        row_d       = row_q;
        col_d       = col_q;
        inb_prev_d  = inb_prev_q;
        taps_d      = taps_q;
        pend_addr_d = pend_addr_q;
        outst_d     = outst_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    fcnt_d  = 4'd0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_FETCH: begin
                // Read data lags the address by one cycle, so the in-bounds
                // flag travels with it to decide between idata and zero.
                inb_prev_d = tap_inb;
                if (fcnt_q != 4'd0) begin
                    taps_d[fcnt_q - 4'd1] = inb_prev_q ? bus.idata : '0;
                end
                if (fcnt_q == K_CAPT) begin
                    state_d = ST_ISSUE;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            ST_ISSUE: begin
                pend_addr_d = {row_q, col_q};
                outst_d     = 1'b1;
                if (last_win) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_FETCH;
                    if (col_q == RC_MAX) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + ROW_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                if (done_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ov_acc) begin
            outst_d = 1'b0;
        end
    end

    always_comb begin
        cwr_d    = 1'b0;
        csel_d   = CSEL_NONE;
        caddr_d  = '0;
        cdata_d  = '0;
        res1_d   = res1_q;
        second_d = 1'b0;
        if (ov_acc) begin
            cwr_d    = 1'b1;
            csel_d   = CSEL_F0;
            caddr_d  = pend_addr_q;
            cdata_d  = bus.k_res0;
            res1_d   = bus.k_res1;
            second_d = 1'b1;
        end else if (second_q) begin
            cwr_d   = 1'b1;
            csel_d  = CSEL_F1;
            caddr_d = caddr_q;
            cdata_d = res1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            inb_prev_q  <= 1'b0;
            taps_q      <= '0;
            pend_addr_q <= '0;
            outst_q     <= 1'b0;
            second_q    <= 1'b0;
            res1_q      <= '0;
            cwr_q       <= 1'b0;
            csel_q      <= CSEL_NONE;
            caddr_q     <= '0;
            cdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            inb_prev_q  <= inb_prev_d;
            taps_q      <= taps_d;
            pend_addr_q <= pend_addr_d;
            outst_q     <= outst_d;
            second_q    <= second_d;
            res1_q      <= res1_d;
            cwr_q       <= cwr_d;
            csel_q      <= csel_d;
            caddr_q     <= caddr_d;
            cdata_q     <= cdata_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_w;
    assign bus.iaddr   = (state_q == ST_FETCH) ? tap_addr : '0;
    assign bus.k_valid = (state_q == ST_ISSUE);
    assign bus.k_data  = taps_q;
    assign bus.cwr     = cwr_q;
    assign bus.csel    = csel_q;
    assign bus.caddr   = caddr_q;
    assign bus.cdata   = cdata_q;

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter IMG_W, 64, image width and height in pixels (square image).
REQ-002 Parameter ADDR_W, 12, pixel address width (log2(IMG_W*IMG_W)).
REQ-003 Parameter DATA_W, 20, pixel/result width, signed fixed point with 16 fractional bits.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to process the full image; ignored while busy=1.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse after the last result write.
REQ-009 iaddr  out  ADDR_W  image memory read address, row-major (row*IMG_W+col).
REQ-010 idata  in  DATA_W  image memory read data, valid one cycle after iaddr (synchronous read).
REQ-011 k_valid  out  1  window-valid strobe to the two-filter convolution datapath.
REQ-012 k_data  out  9*DATA_W  3x3 window; tap k=(dy+1)*3+(dx+1) occupies bits [k*DATA_W +: DATA_W].
REQ-013 k_ovalid  in  1  datapath result strobe; asserts exactly 3 cycles after k_valid; no backpressure.
REQ-014 k_res0, k_res1  in  DATA_W each  filter-0 / filter-1 results, valid with k_ovalid.
REQ-015 cwr  out  1  result memory write enable.
REQ-016 caddr  out  ADDR_W  result write address (equal to the centre-pixel address of the window).
REQ-017 cdata  out  DATA_W  result write data.
REQ-018 csel  out  2  target memory: 2'd1 = filter-0 result memory, 2'd2 = filter-1, 2'd0 = none.

Function
REQ-019 FSM states: IDLE, FETCH, ISSUE, FINISH; IDLE->FETCH on start; FETCH->ISSUE after 9 fetch cycles plus 1 capture cycle; ISSUE->FETCH when windows remain; ISSUE->FINISH after the last window; FINISH->IDLE when the last write completes, with done pulsed in that cycle.
REQ-020 Windows are processed centre-raster order: (row, col) = (0,0), (0,1) .. (IMG_W-1, IMG_W-1), for IMG_W*IMG_W windows total.
REQ-021 FETCH drives iaddr for taps k=0..8 on consecutive cycles; each idata is captured one cycle later into tap slot k.
REQ-022 Taps outside the image (row+dy or col+dx outside 0..IMG_W-1) are stored as zero; iaddr is driven 0 for those cycles.
REQ-023 ISSUE asserts k_valid for exactly one cycle, with k_data holding all 9 captured taps and stable during that cycle.
REQ-024 Each window costs exactly 11 cycles (9 address, 1 capture, 1 issue), independent of padding.
REQ-025 The centre address is latched at ISSUE into a pending-write register; a new window's fetch overlaps the previous window's result writes.
REQ-026 On k_ovalid, k_res0 and k_res1 are captured; the next cycle writes k_res0 with csel=1; the following cycle writes k_res1 with csel=2; both writes use the latched address.
REQ-027 cwr=0 implies csel=0; cdata and caddr are don't-care when cwr=0.
REQ-028 k_ovalid arriving while a write pair is still pending is a protocol error and cannot occur at 11 cycles/window; no buffering beyond one pair is required.
REQ-029 start arriving in the same cycle as done is ignored; a new start is accepted only in IDLE.

Reset
REQ-030 Reset, including reset during operation, forces state IDLE, discards pending windows and writes, and clears busy, done, k_valid, cwr, csel, iaddr, k_data, caddr and cdata to zero.
REQ-031 k_ovalid pulses arriving after reset from in-flight datapath work produce no write.

Structure
REQ-032 A shared package holds IMG_W, ADDR_W, DATA_W, the tap count (9), the csel encodings and the FSM state enumeration.
REQ-033 One sub-module, conv_win_addr, computes the tap address and in-bounds flag from (row, col, k); everything else is in conv_sched.

Verification
REQ-034 Reset mid-FETCH at window 5 -> next cycle all outputs are 0 and no cwr occurs afterwards, including from a later k_ovalid.
REQ-035 Window (0,0) on an image with every pixel = 20'h10000 -> k_data taps 0,1,2,3,6 are 0; taps 4,5,7,8 are 20'h10000.
REQ-036 Window (1,1) -> iaddr sequence is 0,1,2,64,65,66,128,129,130, and k_valid occurs 10 cycles after the first address.
REQ-037 Model datapath returns res0=20'h00123, res1=20'h00456 -> writes caddr=centre, csel=1, cdata=20'h00123, then csel=2, cdata=20'h00456 on consecutive cycles.
REQ-038 Full run from start -> exactly 8192 writes, every address 0..4095 written once per csel, done pulses once, and busy lasts 4096*11 + 3 + 2 cycles.
REQ-039 start pulsed while busy, and start in the done cycle -> no restart; start two cycles after done -> new run begins.
